// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU-side types: the ram word, the ram handshake state and the
//   memory arbiter's FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Reported by the variable-latency ram every cycle.
    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DSERV,
        ISERV
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single variable-latency ram port between the instruction-fetch
//   port and the data port. The grant is registered and held for the whole
//   access, so the ram sees stable enables/address until it reports ACCESS.
//   Ties are broken round-robin; a watchdog abandons accesses that never finish.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   iREN, iaddr               instruction read request / word address
//   iload, iwait              instruction read data / hold-request flag
//   dREN, dWEN, daddr, dstore data read/write request, address, write value
//   dload, dwait              data read data / hold-request flag
//   ramREN, ramWEN, ramaddr,
//   ramstore                  ram request side
//   ramload, ramstate         ram response side
//   memerr                    sticky watchdog flag, cleared only by reset
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; ram enables low, both waits high
// DSERV | data port owns the ram until ACCESS, abort or watchdog expiry
// ISERV | instruction port owns the ram until ACCESS, abort or expiry
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arbstate_t       state, next_state;
    logic            prio, next_prio;
    logic [WD_W-1:0] wdcnt;
    logic            wd_expired;
    logic            set_err;
    logic            d_req, i_req;

    assign d_req      = dREN | dWEN;
    assign i_req      = iREN;
    assign wd_expired = (wdcnt == WD_W'(TIMEOUT - 1));

    // Read data goes straight through; it is only meaningful while the
    // matching wait is low.
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            prio   <= 1'b0;
            wdcnt  <= '0;
            memerr <= 1'b0;
        end else begin
            state  <= next_state;
            prio   <= next_prio;
            memerr <= memerr | set_err;
            // Zero during IDLE, so the first service cycle always starts at 0.
            if (state == IDLE)
                wdcnt <= '0;
            else
                wdcnt <= wdcnt + WD_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        next_prio  = prio;
        set_err    = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;

        case (state)
            IDLE: begin
                if (d_req && i_req)
                    next_state = prio ? ISERV : DSERV;
                else if (d_req)
                    next_state = DSERV;
                else if (i_req)
                    next_state = ISERV;
            end

            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                // Abort takes precedence: a dropped request never sees a
                // wait pulse and leaves the round-robin pointer alone.
                if (!d_req) begin
                    next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait      = 1'b0;
                    next_state = IDLE;
                    next_prio  = 1'b1;
                end else if (wd_expired) begin
                    next_state = IDLE;
                    next_prio  = 1'b1;
                    set_err    = 1'b1;
                end
            end

            ISERV: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!i_req) begin
                    next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait      = 1'b0;
                    next_state = IDLE;
                    next_prio  = 1'b0;
                end else if (wd_expired) begin
                    next_state = IDLE;
                    next_prio  = 1'b0;
                    set_err    = 1'b1;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter against a small variable-latency ram model.
//   The ram latches a request for one cycle, then needs LAT further cycles,
//   so ACCESS appears in the (LAT+2)th cycle after the request was raised.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LAT = 6;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    word_t     iload, dload;
    logic      iwait, dwait;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      memerr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(64)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    // ram model
    word_t mem [0:1023];
    int    cnt = 0;
    bit    stall = 1'b0;

    always @(posedge CLK) begin
        if (!(ramREN || ramWEN))
            cnt <= 0;
        else if (cnt < LAT + 1)
            cnt <= cnt + 1;
        if (ramstate == ACCESS && ramWEN)
            mem[ramaddr[9:0]] <= ramstore;
    end

    always_comb begin
        ramstate = FREE;
        if (ramREN || ramWEN)
            ramstate = (!stall && cnt == LAT + 1) ? ACCESS : BUSY;
    end

    assign ramload = mem[ramaddr[9:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at the start of cycle 0 with the request already raised.
    // Runs grant cycles 1..9; wait must be low exactly in cycle 8.
    task automatic serve(input bit is_i, input word_t addr, input bit is_wr,
                         input bit chk_load, input word_t exp_load, input bit drop);
        string p;
        p = is_i ? "I" : "D";
        for (int c = 1; c <= 9; c++) begin
            @(posedge CLK); #1;
            if (c == 9 && drop) begin
                iREN = 1'b0;
                dREN = 1'b0;
                dWEN = 1'b0;
            end
            @(negedge CLK);
            check($sformatf("%s c%0d granted wait", p, c), 32'(is_i ? iwait : dwait), 32'(c != 8));
            check($sformatf("%s c%0d other wait", p, c), 32'(is_i ? dwait : iwait), 32'd1);
            if (c == 1) begin
                check($sformatf("%s grant ramaddr", p), ramaddr, addr);
                check($sformatf("%s grant ramWEN", p), 32'(ramWEN), 32'(is_wr));
                check($sformatf("%s grant ramREN", p), 32'(ramREN), 32'(!is_wr));
            end
            if (c == 8 && chk_load)
                check($sformatf("%s load", p), is_i ? iload : dload, exp_load);
            if (c == 9)
                check($sformatf("%s idle enables", p), 32'(ramREN | ramWEN), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h040] = 32'hDEADBEEF;
        mem[10'h000] = 32'hA0A0A0A0;
        mem[10'h080] = 32'h0B0B0B0B;

        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;

        // reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst iwait", 32'(iwait), 32'd1);
        check("rst dwait", 32'(dwait), 32'd1);
        check("rst ramREN", 32'(ramREN), 32'd0);
        check("rst ramWEN", 32'(ramWEN), 32'd0);
        check("rst ramaddr", ramaddr, 32'd0);
        check("rst ramstore", ramstore, 32'd0);
        check("rst memerr", 32'(memerr), 32'd0);
        @(posedge CLK); #1 nRST = 1'b1;

        // lone data read
        @(posedge CLK); #1;
        daddr = 32'h40; dREN = 1'b1;
        serve(1'b0, 32'h40, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);

        // write then instruction read of the same word
        @(posedge CLK); #1;
        daddr = 32'h100; dstore = 32'h12345678; dWEN = 1'b1;
        serve(1'b0, 32'h100, 1'b1, 1'b0, '0, 1'b1);
        check("wr commit", mem[10'h100], 32'h12345678);
        @(posedge CLK); #1;
        iaddr = 32'h100; iREN = 1'b1;
        serve(1'b1, 32'h100, 1'b0, 1'b1, 32'h12345678, 1'b1);

        // dWEN and dREN together: write wins
        @(posedge CLK); #1;
        daddr = 32'h200; dstore = 32'h55AA55AA; dWEN = 1'b1; dREN = 1'b1;
        serve(1'b0, 32'h200, 1'b1, 1'b0, '0, 1'b1);
        check("wr+rd commit", mem[10'h200], 32'h55AA55AA);

        // both ports held from reset: D, I, D, I
        @(posedge CLK); #1;
        nRST = 1'b0;
        iaddr = 32'h0; daddr = 32'h80; iREN = 1'b1; dREN = 1'b1;
        @(posedge CLK); #1 nRST = 1'b1;
        serve(1'b0, 32'h80, 1'b0, 1'b1, 32'h0B0B0B0B, 1'b0);
        serve(1'b1, 32'h0,  1'b0, 1'b1, 32'hA0A0A0A0, 1'b0);
        serve(1'b0, 32'h80, 1'b0, 1'b1, 32'h0B0B0B0B, 1'b0);
        serve(1'b1, 32'h0,  1'b0, 1'b1, 32'hA0A0A0A0, 1'b1);

        // granted instruction read dropped in cycle 3, pending data read follows
        @(posedge CLK); #1;
        iaddr = 32'h0; iREN = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge CLK); #1;
            if (c == 2) begin
                daddr = 32'h40; dREN = 1'b1;
            end
            if (c == 3) iREN = 1'b0;
            @(negedge CLK);
            check($sformatf("abort c%0d iwait", c), 32'(iwait), 32'd1);
            check($sformatf("abort c%0d dwait", c), 32'(dwait), 32'd1);
            if (c == 1) check("abort grant ramREN", 32'(ramREN), 32'd1);
            if (c == 4) check("abort idle ramREN", 32'(ramREN), 32'd0);
        end
        serve(1'b0, 32'h40, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);

        // ram stalled: watchdog after 64 service cycles
        stall = 1'b1;
        @(posedge CLK); #1;
        daddr = 32'h40; dREN = 1'b1;
        for (int c = 1; c <= 65; c++) begin
            @(posedge CLK); #1;
            if (c == 65) dREN = 1'b0;
            @(negedge CLK);
            check($sformatf("wd c%0d dwait", c), 32'(dwait), 32'd1);
            if (c == 64) check("wd memerr before", 32'(memerr), 32'd0);
            if (c == 65) begin
                check("wd memerr set", 32'(memerr), 32'd1);
                check("wd idle ramREN", 32'(ramREN), 32'd0);
            end
        end
        stall = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("wd memerr sticky", 32'(memerr), 32'd1);
        @(posedge CLK); #1;
        daddr = 32'h40; dREN = 1'b1;
        serve(1'b0, 32'h40, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        check("wd memerr after access", 32'(memerr), 32'd1);

        // reset in the middle of a write: nothing committed, memerr cleared
        @(posedge CLK); #1;
        daddr = 32'h300; dstore = 32'hCAFEF00D; dWEN = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("midrst granted ramWEN", 32'(ramWEN), 32'd1);
        @(posedge CLK); #1 nRST = 1'b0;
        @(negedge CLK);
        check("midrst ramWEN", 32'(ramWEN), 32'd0);
        check("midrst ramaddr", ramaddr, 32'd0);
        check("midrst dwait", 32'(dwait), 32'd1);
        check("midrst memerr", 32'(memerr), 32'd0);
        repeat (8) @(posedge CLK);
        #1 dWEN = 1'b0; nRST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("midrst no write", mem[10'h300], 32'd0);
        check("midrst idle dwait", 32'(dwait), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
